// File: rtl/axi_lite_reg_ctrl_if.sv
// AXI4-Lite slave bus bundle for the register controller.
// Master drives requests; slave returns ready/response signals.
interface axi_lite_reg_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12
);
    logic [ADDR_W-1:0]   S_AXI_AWADDR;
    logic                S_AXI_AWVALID;
    logic                S_AXI_AWREADY;
    logic [DATA_W-1:0]   S_AXI_WDATA;
    logic [DATA_W/8-1:0] S_AXI_WSTRB;
    logic                S_AXI_WVALID;
    logic                S_AXI_WREADY;
    logic [1:0]          S_AXI_BRESP;
    logic                S_AXI_BVALID;
    logic                S_AXI_BREADY;
    logic [ADDR_W-1:0]   S_AXI_ARADDR;
    logic                S_AXI_ARVALID;
    logic                S_AXI_ARREADY;
    logic [DATA_W-1:0]   S_AXI_RDATA;
    logic [1:0]          S_AXI_RRESP;
    logic                S_AXI_RVALID;
    logic                S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARVALID,
        output S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARVALID,
        input  S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/axi_lite_reg_ctrl.sv
// AXI4-Lite slave front-end: one transaction at a time, fair
// write/read arbitration, 256-byte window decode to NUM_BLK blocks.
module axi_lite_reg_ctrl #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int NUM_BLK            = 4,
    parameter int RD_LAT             = 1
) (
    input  logic                              S_AXI_ACLK,
    input  logic                              S_AXI_ARESET,
    axi_lite_reg_ctrl_if.slave                s_axi,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     blk_awaddr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     blk_wdata,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0]   blk_wstrb,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]     blk_araddr,
    output logic [NUM_BLK-1:0]                blk_wren,
    output logic [NUM_BLK-1:0]                blk_rden,
    input  logic [NUM_BLK*C_S_AXI_DATA_WIDTH-1:0] blk_rdata
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int AW = C_S_AXI_ADDR_WIDTH;
    localparam int SW = DW / 8;

    typedef enum logic [2:0] {
        IDLE, WR_STB, WR_RESP, RD_STB, RD_WAIT, RD_RESP
    } state_t;

    state_t        state_q, state_d;
    logic          last_wr_q, last_wr_d;
    logic [AW-1:0] awaddr_q, awaddr_d;
    logic [AW-1:0] araddr_q, araddr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [SW-1:0] wstrb_q, wstrb_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [3:0]    cnt_q, cnt_d;

    logic [3:0]    aw_sel, ar_sel;
    logic          aw_map, ar_map;
    logic          wr_req, rd_req;
    logic          gnt_wr, gnt_rd;
    logic [DW-1:0] rd_mux;

    assign aw_sel = awaddr_q[11:8];
    assign ar_sel = araddr_q[11:8];
    assign aw_map = ({1'b0, aw_sel} < 5'(NUM_BLK));
    assign ar_map = ({1'b0, ar_sel} < 5'(NUM_BLK));

    assign wr_req = s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
    assign rd_req = s_axi.S_AXI_ARVALID;

    // Ties go to the opposite of the last grant; reset forces READY low.
    assign gnt_wr = (state_q == IDLE) & ~S_AXI_ARESET & wr_req
                  & (~rd_req | ~last_wr_q);
    assign gnt_rd = (state_q == IDLE) & ~S_AXI_ARESET & rd_req
                  & ~gnt_wr;

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_BLK; i++) begin
            if (ar_sel == 4'(i)) rd_mux = blk_rdata[i*DW +: DW];
        end
    end

    always_comb begin
        state_d   = state_q;
        last_wr_d = last_wr_q;
        awaddr_d  = awaddr_q;
        araddr_d  = araddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (gnt_wr) begin
                    awaddr_d  = s_axi.S_AXI_AWADDR;
                    wdata_d   = s_axi.S_AXI_WDATA;
                    wstrb_d   = s_axi.S_AXI_WSTRB;
                    last_wr_d = 1'b1;
                    state_d   = WR_STB;
                end else if (gnt_rd) begin
                    araddr_d  = s_axi.S_AXI_ARADDR;
                    last_wr_d = 1'b0;
                    state_d   = RD_STB;
                end
            end
            WR_STB: state_d = WR_RESP;
            WR_RESP: begin
                if (s_axi.S_AXI_BREADY) state_d = IDLE;
            end
            RD_STB: begin
                cnt_d   = 4'(RD_LAT - 1);
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = ar_map ? rd_mux : '0;
                    rresp_d = ar_map ? 2'b00 : 2'b11;
                    state_d = RD_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RD_RESP: begin
                if (s_axi.S_AXI_RREADY) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or posedge S_AXI_ARESET) begin
        if (S_AXI_ARESET) begin
            state_q   <= IDLE;
            last_wr_q <= 1'b0;
            awaddr_q  <= '0;
            araddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= 2'b00;
            cnt_q     <= 4'd0;
        end else begin
            state_q   <= state_d;
            last_wr_q <= last_wr_d;
            awaddr_q  <= awaddr_d;
            araddr_q  <= araddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            cnt_q     <= cnt_d;
        end
    end

    always_comb begin
        blk_wren = '0;
        blk_rden = '0;
        for (int i = 0; i < NUM_BLK; i++) begin
            blk_wren[i] = (state_q == WR_STB) && (aw_sel == 4'(i));
            blk_rden[i] = (state_q == RD_STB) && (ar_sel == 4'(i));
        end
    end

    assign blk_awaddr = awaddr_q;
    assign blk_wdata  = wdata_q;
    assign blk_wstrb  = wstrb_q;
    assign blk_araddr = araddr_q;

    assign s_axi.S_AXI_AWREADY = gnt_wr;
    assign s_axi.S_AXI_WREADY  = gnt_wr;
    assign s_axi.S_AXI_ARREADY = gnt_rd;
    assign s_axi.S_AXI_BVALID  = (state_q == WR_RESP);
    assign s_axi.S_AXI_BRESP   = ((state_q == WR_RESP) && !aw_map)
                               ? 2'b11 : 2'b00;
    assign s_axi.S_AXI_RVALID  = (state_q == RD_RESP);
    assign s_axi.S_AXI_RDATA   = rdata_q;
    assign s_axi.S_AXI_RRESP   = (state_q == RD_RESP) ? rresp_q : 2'b00;
endmodule

// File: doc/axi_lite_reg_ctrl.md
Name: axi_lite_reg_ctrl

Overview:
AXI4-Lite slave front-end that sequences all register traffic to the design's register sub-blocks (common/version block, test registers, later peripherals). It accepts AXI4-Lite write and read transactions one at a time. It arbitrates fairly between a pending write and a pending read, and decodes each address to one of NUM_BLK 256-byte register windows. It issues single-cycle wren/rden strobes to the selected block, captures read data after a fixed latency, and returns OKAY or DECERR responses.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width (32 only)
C_S_AXI_ADDR_WIDTH, 12, byte address width; addr[11:8] selects the block window
NUM_BLK, 4, number of mapped windows (1..16); windows 0..NUM_BLK-1 are mapped
RD_LAT, 1, cycles from rden pulse to valid blk_rdata (1..15)

Ports:
S_AXI_ACLK  in  1  clock
S_AXI_ARESET  in  1  asynchronous reset, active-high
S_AXI_AWADDR  in  ADDR_W  write address
S_AXI_AWVALID  in  1  write address valid
S_AXI_AWREADY  out  1  write address accept
S_AXI_WDATA  in  DATA_W  write data
S_AXI_WSTRB  in  DATA_W/8  byte strobes
S_AXI_WVALID  in  1  write data valid
S_AXI_WREADY  out  1  write data accept
S_AXI_BRESP  out  2  write response
S_AXI_BVALID  out  1  write response valid
S_AXI_BREADY  in  1  write response accept
S_AXI_ARADDR  in  ADDR_W  read address
S_AXI_ARVALID  in  1  read address valid
S_AXI_ARREADY  out  1  read address accept
S_AXI_RDATA  out  DATA_W  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID  out  1  read data valid
S_AXI_RREADY  in  1  read data accept
blk_awaddr  out  ADDR_W  latched write address to all blocks
blk_wdata  out  DATA_W  latched write data
blk_wstrb  out  DATA_W/8  latched strobes
blk_araddr  out  ADDR_W  latched read address
blk_wren  out  NUM_BLK  one-hot write strobe
blk_rden  out  NUM_BLK  one-hot read strobe
blk_rdata  in  NUM_BLK*DATA_W  read data; block i occupies slice i

Behaviour:
- Reset (async, active-high): state IDLE; all outputs are 0 (READY/VALID low, RESP 00, RDATA 0, strobes 0, latched buses 0); last_grant = READ. An in-flight transaction is dropped and no response is issued.
- FSM states: IDLE, WR_STB, WR_RESP, RD_STB, RD_WAIT, RD_RESP.
- IDLE:
  - A write is eligible only when AWVALID and WVALID are both high. A read is eligible when ARVALID is high.
  - If only one is eligible, grant it. If both are eligible, grant the opposite of last_grant, so after reset the write wins.
  - On a write grant, AWREADY and WREADY pulse together for one cycle. AWADDR, WDATA and WSTRB are latched, last_grant=WRITE, next state WR_STB.
  - On a read grant, ARREADY pulses for one cycle. ARADDR is latched, last_grant=READ, next state RD_STB.
  - READY outputs are never high outside this grant cycle.
- Decode: sel = addr[11:8]. The address is mapped iff sel < NUM_BLK. addr[7:0] is passed through unchanged in blk_*addr.
- WR_STB: blk_wren[sel] is high for exactly one cycle if mapped, else no strobe. WSTRB=0 still strobes. Next state WR_RESP.
- WR_RESP: BVALID=1; BRESP=00 if mapped, 11 (DECERR) if unmapped. Hold until BREADY is sampled high, then go to IDLE.
- RD_STB: blk_rden[sel] is high for one cycle if mapped. Load counter=RD_LAT-1. Next state RD_WAIT.
- RD_WAIT: decrement the counter. When it reaches 0, register RDATA = blk_rdata slice sel (0 if unmapped) and RRESP = 00/11. Next state RD_RESP.
- RD_RESP: RVALID=1; RDATA and RRESP are held stable until RREADY, then go to IDLE.
- Latency with READY high and handshake in cycle T:
  - Write: wren in T+1, BVALID in T+2.
  - Read: rden in T+1, data sampled end of T+RD_LAT+1, RVALID in T+RD_LAT+2.
- Only one outstanding transaction. New AW/W/AR requests are ignored (READY low) until return to IDLE. The earliest next grant is the cycle after the B or R handshake.
- AWVALID without WVALID, or the reverse, waits indefinitely and does not block reads.

Test Plan:
- Write 0xA5A5_0001 to 0x208 with BREADY=1 -> AW/WREADY in T, blk_wren=0100 in T+1 only, blk_awaddr=0x208, BVALID in T+2 with BRESP=00.
- Read 0x004 with blk_rdata slice0=0x2024_0611, RD_LAT=1 -> ARREADY in T, blk_rden=0001 in T+1, RVALID in T+3, RDATA=0x2024_0611, RRESP=00.
- AWVALID, WVALID and ARVALID high together from reset, held, then re-issued -> grant order is write, read, write, read (strict alternation).
- Access 0x500 with NUM_BLK=4 -> no wren/rden pulse; BRESP=11; RRESP=11 with RDATA=0.
- Hold RREADY low for 5 cycles -> RVALID and RDATA stay stable; ARREADY stays low despite ARVALID; the next grant comes the cycle after the handshake.
- Assert S_AXI_ARESET during RD_WAIT -> all outputs 0 immediately; no RVALID; after release, a write is granted first.
